// File: rtl/rename_regfile_2c.sv
// rename_regfile_2c
// -----------------------------------------------------------------------------
// Architectural register file with per-register rename tags. It sits between
// dispatch and the ROB of the Tomasulo core.
//
// Each cycle the block can:
//   - rename one destination register (ren_*),
//   - read two source operands (rs1/rs2 -> rs*_val/busy/tag),
//   - accept two in-order commits (cm_*).
// Channel 0 is the older commit and channel 1 is the younger one.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ren_valid/ren_rd/ren_tag  destination rename from dispatch
//   rs1, rs2                  source indices, read combinationally
//   rs1_val/busy/tag          source 1 value, pending flag, producer ROB id
//   rs2_val/busy/tag          same as source 1, for rs2
//   cm_valid[1:0]             commit channel valids (bit 0 = older)
//   cm_rd/cm_tag/cm_data      packed per-channel commit fields
//   rollback                  ROB flush: clears every mapping
//
// Optional build macro RENAME_REGFILE_BYPASS_EN:
//   When this macro is defined, the read ports forward the commits of the same
//   cycle. When it is undefined, reads show only the registered state.
// -----------------------------------------------------------------------------
module rename_regfile_2c #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren_valid,
    input  logic [REG_AW-1:0]     ren_rd,
    input  logic [ROB_W-1:0]      ren_tag,
    input  logic [REG_AW-1:0]     rs1,
    input  logic [REG_AW-1:0]     rs2,
    output logic [DATA_W-1:0]     rs1_val,
    output logic                  rs1_busy,
    output logic [ROB_W-1:0]      rs1_tag,
    output logic [DATA_W-1:0]     rs2_val,
    output logic                  rs2_busy,
    output logic [ROB_W-1:0]      rs2_tag,
    input  logic [1:0]            cm_valid,
    input  logic [2*REG_AW-1:0]   cm_rd,
    input  logic [2*ROB_W-1:0]    cm_tag,
    input  logic [2*DATA_W-1:0]   cm_data,
    input  logic                  rollback
);

    // Architectural state
    logic [DATA_W-1:0]   val_q  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [ROB_W-1:0]    tag_q  [NUM_REGS];

    // Unpacked commit channels
    logic [REG_AW-1:0]   cm_rd_a   [2];
    logic [ROB_W-1:0]    cm_tag_a  [2];
    logic [DATA_W-1:0]   cm_data_a [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cm_rd_a[k]   = cm_rd[k*REG_AW +: REG_AW];
            cm_tag_a[k]  = cm_tag[k*ROB_W +: ROB_W];
            cm_data_a[k] = cm_data[k*DATA_W +: DATA_W];
        end
    end

    // Per-register decode of this cycle's requests. Register 0 never matches,
    // so renames and commits to x0 fall away here.
    logic [NUM_REGS-1:0] ren_hit;
    logic [NUM_REGS-1:0] cm_hit0;
    logic [NUM_REGS-1:0] cm_hit1;
    logic [NUM_REGS-1:0] clr_hit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ren_hit = '0;
        cm_hit0 = '0;
        cm_hit1 = '0;
        clr_hit = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            // A rollback drops a rename made in the same cycle.
            ren_hit[i] = ren_valid && !rollback && (ren_rd == REG_AW'(i));
            cm_hit0[i] = cm_valid[0] && (cm_rd_a[0] == REG_AW'(i));
            cm_hit1[i] = cm_valid[1] && (cm_rd_a[1] == REG_AW'(i));
            // The register is released only when the committing ROB id
            // still owns it. A younger producer keeps the mapping.
            clr_hit[i] = busy_q[i] &&
                         ((cm_hit0[i] && (tag_q[i] == cm_tag_a[0])) ||
                          (cm_hit1[i] && (tag_q[i] == cm_tag_a[1])));
        end
    end

    // State update
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the value array is reset together with the mapping state
            // because the reads must return zero immediately after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                // NOTE: the sequential state uses non-blocking assignments so
                // that every read in this block sees the value from the start
                // of the cycle.
                if (cm_hit1[i]) begin
                    val_q[i] <= cm_data_a[1];          // younger commit wins
                end else if (cm_hit0[i]) begin
                    val_q[i] <= cm_data_a[0];
                end

                if (rollback) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end else if (ren_hit[i]) begin
                    busy_q[i] <= 1'b1;                 // new producer takes over
                    tag_q[i]  <= ren_tag;
                end else if (clr_hit[i]) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end
            end
        end
    end

    // Read ports: combinational from the state at the start of the cycle.
    logic [REG_AW-1:0] rd_idx  [2];
    logic [DATA_W-1:0] rd_val  [2];
    logic              rd_busy [2];
    logic [ROB_W-1:0]  rd_tag  [2];

    always_comb begin
        rd_idx[0] = rs1;
        rd_idx[1] = rs2;
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = val_q[rd_idx[p]];
            rd_busy[p] = busy_q[rd_idx[p]];
            rd_tag[p]  = tag_q[rd_idx[p]];
`ifdef RENAME_REGFILE_BYPASS_EN
            // Forward the commits of this cycle. Channel 1 is evaluated last,
            // so its value takes precedence over channel 0.
            for (int k = 0; k < 2; k++) begin
                if (cm_valid[k] && (cm_rd_a[k] == rd_idx[p]) && (rd_idx[p] != '0)) begin
                    rd_val[p] = cm_data_a[k];
                    if (busy_q[rd_idx[p]] && (tag_q[rd_idx[p]] == cm_tag_a[k])) begin
                        rd_busy[p] = 1'b0;
                    end
                end
            end
`endif
            if (rd_idx[p] == '0) begin
                rd_val[p]  = '0;
                rd_busy[p] = 1'b0;
            end
            if (!rd_busy[p]) begin
                rd_tag[p] = '0;
            end
        end
    end

    assign rs1_val  = rd_val[0];
    assign rs1_busy = rd_busy[0];
    assign rs1_tag  = rd_tag[0];
    assign rs2_val  = rd_val[1];
    assign rs2_busy = rd_busy[1];
    assign rs2_tag  = rd_tag[1];

endmodule
